// File: rtl/logic_pipe_pkg.sv
// Shared opcode encoding and opcode width for logic_pipe.
package logic_pipe_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_AND  = 3'd0;
  localparam logic [OPW-1:0] OP_OR   = 3'd1;
  localparam logic [OPW-1:0] OP_XOR  = 3'd2;
  localparam logic [OPW-1:0] OP_NOR  = 3'd3;
  localparam logic [OPW-1:0] OP_NAND = 3'd4;
  localparam logic [OPW-1:0] OP_XNOR = 3'd5;
  localparam logic [OPW-1:0] OP_ANDN = 3'd6;
  localparam logic [OPW-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_pipe_stage.sv
// Generic valid/ready register slice: a valid bit plus a data word, advanced by en.
module logic_pipe_stage #(
  parameter int unsigned   DW      = 8,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  // Data only loads with a valid entry so an empty slot keeps its last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= RST_VAL;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// Two-stage valid/ready bitwise logic pipeline.
// Optional LOGIC_PIPE_FLAGS_EN adds registered out_zero/out_parity flags.
module logic_pipe #(
  parameter int WIDTH = 32,
  parameter int OPW   = logic_pipe_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_PIPE_FLAGS_EN
  output logic             out_zero,
  output logic             out_parity,
`endif
  output logic [WIDTH-1:0] out1
);

  import logic_pipe_pkg::*;

  localparam int unsigned S1W = OPW + 2 * WIDTH;
`ifdef LOGIC_PIPE_FLAGS_EN
  localparam int unsigned S2W = WIDTH + 2;
  localparam logic [S2W-1:0] S2_RST = {1'b1, {(WIDTH + 1){1'b0}}};
`else
  localparam int unsigned S2W = WIDTH;
  localparam logic [S2W-1:0] S2_RST = '0;
`endif

  function automatic logic [WIDTH-1:0] eval_op(input logic [OPW-1:0]   o,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = a;
    case (o)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  logic           s1_en, s2_en;
  logic           s1_valid;
  logic [S1W-1:0] s1_data;
  logic [S2W-1:0] s2_data;
  logic [S2W-1:0] s2_next;

  logic [OPW-1:0]   s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, result;

  always_comb begin
    s2_en    = !out_valid || out_ready;
    s1_en    = !s1_valid || s2_en;
    in_ready = s1_en;
  end

  logic_pipe_stage #(
    .DW      (S1W),
    .RST_VAL ('0)
  ) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (s1_en),
    .in_valid  (in_valid),
    .in_data   ({op, in2, in1}),
    .out_valid (s1_valid),
    .out_data  (s1_data)
  );

  assign {s1_op, s1_b, s1_a} = s1_data;
  assign result = eval_op(s1_op, s1_a, s1_b);

`ifdef LOGIC_PIPE_FLAGS_EN
  assign s2_next    = {~|result, ^result, result};
  assign out_zero   = s2_data[WIDTH+1];
  assign out_parity = s2_data[WIDTH];
`else
  assign s2_next = result;
`endif

  logic_pipe_stage #(
    .DW      (S2W),
    .RST_VAL (S2_RST)
  ) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (s2_en),
    .in_valid  (s1_valid),
    .in_data   (s2_next),
    .out_valid (out_valid),
    .out_data  (s2_data)
  );

  assign out1 = s2_data[WIDTH-1:0];

endmodule

// File: tb/tb_logic_pipe.sv
// Directed and scoreboard bench for logic_pipe at WIDTH 8, 1 and 64.
module tb_logic_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // WIDTH=8 instance
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in1, in2, out1;
  logic [2:0] op;
`ifdef LOGIC_PIPE_FLAGS_EN
  logic f8_zero, f8_parity, f1_zero, f1_parity, f64_zero, f64_parity;
`endif

  logic_pipe #(.WIDTH(8)) u_w8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef LOGIC_PIPE_FLAGS_EN
    .out_zero   (f8_zero),
    .out_parity (f8_parity),
`endif
    .out1       (out1)
  );

  // WIDTH=1 and WIDTH=64 instances share handshake stimulus
  logic        rv_in_valid, rv_out_ready;
  logic [2:0]  rv_op;
  logic [63:0] w64_in1, w64_in2, w64_out1;
  logic        w64_in_ready, w64_out_valid;
  logic        w1_in_ready, w1_out_valid, w1_out1;

  logic_pipe #(.WIDTH(64)) u_w64 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (rv_in_valid),
    .in_ready   (w64_in_ready),
    .in1        (w64_in1),
    .in2        (w64_in2),
    .op         (rv_op),
    .out_valid  (w64_out_valid),
    .out_ready  (rv_out_ready),
`ifdef LOGIC_PIPE_FLAGS_EN
    .out_zero   (f64_zero),
    .out_parity (f64_parity),
`endif
    .out1       (w64_out1)
  );

  logic_pipe #(.WIDTH(1)) u_w1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (rv_in_valid),
    .in_ready   (w1_in_ready),
    .in1        (w64_in1[0]),
    .in2        (w64_in2[0]),
    .op         (rv_op),
    .out_valid  (w1_out_valid),
    .out_ready  (rv_out_ready),
`ifdef LOGIC_PIPE_FLAGS_EN
    .out_zero   (f1_zero),
    .out_parity (f1_parity),
`endif
    .out1       (w1_out1)
  );

  // Per-bit truth table indexed by {a,b}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [3:0]  tt;
    logic [63:0] r;
    case (o)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b0001;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0100;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 64; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic drive8(input logic v, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b);
    in_valid = v;
    op       = o;
    in1      = a;
    in2      = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive8(1'b0, 3'd0, 8'h00, 8'h00);
    out_ready    = 1'b1;
    rv_in_valid  = 1'b0;
    rv_out_ready = 1'b1;
    rv_op        = 3'd0;
    w64_in1      = '0;
    w64_in2      = '0;
    #3;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0 || out1 !== 8'h00) begin
      n_fail++; $display("FAIL reset_out: got valid=%b out1=%h, expected 0/00", out_valid, out1);
    end
    n_tests++;
    if (w64_out_valid !== 1'b0 || w64_out1 !== 64'h0) begin
      n_fail++; $display("FAIL reset_w64: got valid=%b out1=%h, expected 0/0", w64_out_valid,
                         w64_out1);
    end
`ifdef LOGIC_PIPE_FLAGS_EN
    n_tests++;
    if (f8_zero !== 1'b1 || f8_parity !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got zero=%b parity=%b, expected 1/0", f8_zero,
                         f8_parity);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got ready=%b valid=%b, expected 1/0", in_ready,
                         out_valid);
    end
  endtask

  task automatic test_ops();
    logic [7:0] exp_v [8];
    exp_v = '{8'h30, 8'hFC, 8'hCC, 8'h03, 8'hCF, 8'h33, 8'hC0, 8'hF0};
    out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k < 8) drive8(1'b1, 3'(k), 8'hF0, 8'h3C);
      else drive8(1'b0, 3'd0, 8'h00, 8'h00);
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL ops_ready[%0d]: got %b, expected 1", k, in_ready);
      end
      if (k >= 2 && k <= 9) begin
        n_tests++;
        if (out_valid !== 1'b1 || out1 !== exp_v[k-2]) begin
          n_fail++; $display("FAIL ops_op%0d: got valid=%b out1=%h, expected 1/%h", k - 2,
                             out_valid, out1, exp_v[k-2]);
        end
      end else begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL ops_idle[%0d]: got valid=%b, expected 0", k, out_valid);
        end
      end
    end
  endtask

  task automatic test_stall_op_hold();
    int acc;
    acc = 0;
    out_ready = 1'b0;
    @(posedge clk); #1; drive8(1'b1, 3'd0, 8'hF0, 8'h3C);
    @(negedge clk); if (in_ready) acc++;
    @(posedge clk); #1; drive8(1'b1, 3'd2, 8'h0F, 8'h3C);
    @(negedge clk); if (in_ready) acc++;
    // S1 entry (XOR) sits stalled while the op bus toggles to PASS/NAND
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1; drive8(1'b1, (k == 0) ? 3'd7 : 3'd4, 8'h01, 8'h02);
      @(negedge clk); if (in_ready) acc++;
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out1 !== 8'h30) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got ready=%b valid=%b out1=%h, expected 0/1/30",
                           k, in_ready, out_valid, out1);
      end
    end
    n_tests++;
    if (acc != 2) begin
      n_fail++; $display("FAIL stall_accepted: got %0d, expected 2", acc);
    end
    @(posedge clk); #1; drive8(1'b1, 3'd1, 8'h01, 8'h02); out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out1 !== 8'h30) begin
      n_fail++; $display("FAIL release_r0: got ready=%b valid=%b out1=%h, expected 1/1/30",
                         in_ready, out_valid, out1);
    end
    @(posedge clk); #1; drive8(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out1 !== 8'h33) begin
      n_fail++; $display("FAIL release_r1_op_captured: got valid=%b out1=%h, expected 1/33",
                         out_valid, out1);
    end
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out1 !== 8'h03) begin
      n_fail++; $display("FAIL release_r2: got valid=%b out1=%h, expected 1/03", out_valid, out1);
    end
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL release_drain: got valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; drive8(1'b1, 3'd1, 8'hAA, 8'h55);
      @(negedge clk);
    end
    n_tests++;
    if (out_valid !== 1'b1 || out1 !== 8'hFF) begin
      n_fail++; $display("FAIL mid_pre: got valid=%b out1=%h, expected 1/FF", out_valid, out1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out1 !== 8'h00 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_async_clear: got valid=%b out1=%h ready=%b, expected 0/00/1",
                         out_valid, out1, in_ready);
    end
    drive8(1'b0, 3'd0, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || out1 !== 8'h00) begin
        n_fail++; $display("FAIL mid_no_stale[%0d]: got valid=%b out1=%h, expected 0/00", k,
                           out_valid, out1);
      end
    end
  endtask

`ifdef LOGIC_PIPE_FLAGS_EN
  task automatic test_flags();
    logic [7:0] eo [3];
    logic       ez [3];
    logic       ep [3];
    eo = '{8'h00, 8'h03, 8'h07};
    ez = '{1'b1, 1'b0, 1'b0};
    ep = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      case (k)
        0:       drive8(1'b1, 3'd2, 8'hA5, 8'hA5);
        1:       drive8(1'b1, 3'd1, 8'h01, 8'h02);
        2:       drive8(1'b1, 3'd7, 8'h07, 8'h00);
        default: drive8(1'b0, 3'd0, 8'h00, 8'h00);
      endcase
      @(negedge clk);
      if (k >= 2) begin
        n_tests++;
        if (out_valid !== 1'b1 || out1 !== eo[k-2] || f8_zero !== ez[k-2] ||
            f8_parity !== ep[k-2]) begin
          n_fail++; $display("FAIL flags[%0d]: got out1=%h zero=%b parity=%b, expected %h/%b/%b",
                             k - 2, out1, f8_zero, f8_parity, eo[k-2], ez[k-2], ep[k-2]);
        end
      end
    end
  endtask
`endif

  task automatic test_random_widths();
    logic [63:0] q [$];
    logic [63:0] e;
    logic        pending;
    pending = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (!pending) begin
        rv_in_valid = ($urandom_range(3) != 0);
        rv_op       = 3'($urandom_range(7));
        w64_in1     = {$urandom, $urandom};
        w64_in2     = {$urandom, $urandom};
      end
      rv_out_ready = (c >= 240) ? 1'b1 : 1'($urandom_range(1));
      if (c >= 240 && c < 280) rv_in_valid = 1'b1;
      if (c >= 280) rv_in_valid = 1'b0;
      @(negedge clk);
      if (w64_out_valid && rv_out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra[%0d]: got out1=%h, expected no result", c,
                             w64_out1);
        end else begin
          e = q.pop_front();
          if (w64_out1 !== e || w1_out_valid !== 1'b1 || w1_out1 !== e[0]) begin
            n_fail++; $display("FAIL rand_result[%0d]: got w64=%h w1=%b/%b, expected %h/1/%b",
                               c, w64_out1, w1_out_valid, w1_out1, e, e[0]);
          end
        end
      end
      if (c >= 242 && c < 280) begin
        n_tests++;
        if (w64_in_ready !== 1'b1 || w64_out_valid !== 1'b1 || w1_in_ready !== 1'b1) begin
          n_fail++; $display("FAIL rand_throughput[%0d]: got ready=%b valid=%b, expected 1/1",
                             c, w64_in_ready, w64_out_valid);
        end
      end
      if (rv_in_valid && w64_in_ready) begin
        q.push_back(model(rv_op, w64_in1, w64_in2));
        pending = 1'b0;
      end else begin
        pending = rv_in_valid;
      end
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL rand_drain: got %0d outstanding, expected 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_stall_op_hold();
    test_reset_mid();
`ifdef LOGIC_PIPE_FLAGS_EN
    test_flags();
`endif
    test_random_widths();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
